// File: rtl/shift_ex_stage_if.sv
// ============================================================================
// shift_ex_stage_if : op-in / result-out handshake bundle of shift_ex_stage
// Revision: 1.0
// ============================================================================
`default_nettype none

interface shift_ex_stage_if #(
    parameter int XLEN = 32
);
    // Field names are written from the execute stage's point of view
    logic            valid_i;
    logic            ready_o;
    logic [1:0]      op_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic [4:0]      rd_addr_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] rd_o;
    logic [4:0]      rd_addr_o;

    modport slave (
        input  valid_i, op_i, rs1_i, rs2_i, rd_addr_i, ready_i,
        output ready_o, valid_o, rd_o, rd_addr_o
    );

    modport master (
        output valid_i, op_i, rs1_i, rs2_i, rd_addr_i, ready_i,
        input  ready_o, valid_o, rd_o, rd_addr_o
    );
endinterface

`default_nettype wire

// File: rtl/shift_ex_stage.sv
// ============================================================================
// shift_ex_stage : two-stage SLL/SRL/SRA execute unit with flush and counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module shift_ex_stage #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5,
    parameter int CNT_W   = 32
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    input  wire logic             flush_i,
    shift_ex_stage_if.slave       bus,
    output logic [CNT_W-1:0]      op_count_o
);
    localparam logic [1:0] c_OP_SLL  = 2'b00;
    localparam logic [1:0] c_OP_SRL  = 2'b01;
    localparam logic [1:0] c_OP_SRA  = 2'b11;

    logic               a_valid_q, a_valid_d;
    logic [1:0]         a_op_q, a_op_d;
    logic [XLEN-1:0]    a_rs1_q, a_rs1_d;
    logic [SHAMT_W-1:0] a_shamt_q, a_shamt_d;
    logic [4:0]         a_rd_addr_q, a_rd_addr_d;
    logic               b_valid_q, b_valid_d;
    logic [XLEN-1:0]    b_rd_q, b_rd_d;
    logic [4:0]         b_rd_addr_q, b_rd_addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               w_b_free;
    logic               w_a_move;
    logic               w_accept;
    logic [XLEN-1:0]    w_result;
    logic               w_unused_rs2;

    assign w_b_free     = !b_valid_q || bus.ready_i;
    assign w_a_move     = a_valid_q && w_b_free;
    assign w_accept     = bus.valid_i && bus.ready_o;
    assign w_unused_rs2 = ^bus.rs2_i[XLEN-1:SHAMT_W];

    // ready_o deliberately ignores valid_i to keep the upstream path short
    assign bus.ready_o   = !a_valid_q || w_b_free;
    assign bus.valid_o   = b_valid_q;
    assign bus.rd_o      = b_rd_q;
    assign bus.rd_addr_o = b_rd_addr_q;
    assign op_count_o    = cnt_q;

    always_comb begin
        w_result = a_rs1_q;
        case (a_op_q)
            c_OP_SLL: w_result = a_rs1_q << a_shamt_q;
            c_OP_SRL: w_result = a_rs1_q >> a_shamt_q;
            c_OP_SRA: w_result = XLEN'($signed(a_rs1_q) >>> a_shamt_q);
            default:  w_result = a_rs1_q;
        endcase
    end

    always_comb begin
        a_valid_d   = a_valid_q;
        a_op_d      = a_op_q;
        a_rs1_d     = a_rs1_q;
        a_shamt_d   = a_shamt_q;
        a_rd_addr_d = a_rd_addr_q;
        b_valid_d   = b_valid_q;
        b_rd_d      = b_rd_q;
        b_rd_addr_d = b_rd_addr_q;
        cnt_d       = cnt_q;

        if (w_accept) begin
            a_op_d      = bus.op_i;
            a_rs1_d     = bus.rs1_i;
            a_shamt_d   = bus.rs2_i[SHAMT_W-1:0];
            a_rd_addr_d = bus.rd_addr_i;
        end
        if (w_a_move) begin
            b_rd_d      = w_result;
            b_rd_addr_d = a_rd_addr_q;
        end

        // Flush only kills valids; stale data in the regs is harmless
        if (flush_i)        a_valid_d = 1'b0;
        else if (w_accept)  a_valid_d = 1'b1;
        else if (w_a_move)  a_valid_d = 1'b0;

        if (flush_i)          b_valid_d = 1'b0;
        else if (w_a_move)    b_valid_d = 1'b1;
        else if (bus.ready_i) b_valid_d = 1'b0;

        if (b_valid_q && bus.ready_i && !flush_i)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_valid_q   <= 1'b0;
            a_op_q      <= '0;
            a_rs1_q     <= '0;
            a_shamt_q   <= '0;
            a_rd_addr_q <= '0;
            b_valid_q   <= 1'b0;
            b_rd_q      <= '0;
            b_rd_addr_q <= '0;
            cnt_q       <= '0;
        end else begin
            a_valid_q   <= a_valid_d;
            a_op_q      <= a_op_d;
            a_rs1_q     <= a_rs1_d;
            a_shamt_q   <= a_shamt_d;
            a_rd_addr_q <= a_rd_addr_d;
            b_valid_q   <= b_valid_d;
            b_rd_q      <= b_rd_d;
            b_rd_addr_q <= b_rd_addr_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_shift_ex_stage.sv
// ============================================================================
// tb_shift_ex_stage : directed-vector bench for shift_ex_stage
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_shift_ex_stage;
    localparam int XLEN = 32;
    localparam int CNTW = 32;
    localparam int N_B2B = 100;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            flush_i;
    logic [CNTW-1:0] op_count_o;
    int              vectors = 0;
    int              miscompares = 0;
    logic [CNTW-1:0] exp_cnt = '0;

    shift_ex_stage_if #(.XLEN(XLEN)) bus ();

    shift_ex_stage #(.XLEN(XLEN), .SHAMT_W(5), .CNT_W(CNTW)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .bus        (bus),
        .op_count_o (op_count_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        int unsigned s;
        logic [31:0] ones;
        s = b % 32;
        ones = 32'hFFFF_FFFF;
        case (op)
            2'b00:   return a << s;
            2'b01:   return a >> s;
            2'b11:   return (a >> s) | (a[31] ? ~(ones >> s) : 32'h0);
            default: return a;
        endcase
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] addr);
        bus.valid_i   = v;
        bus.op_i      = op;
        bus.rs1_i     = a;
        bus.rs2_i     = b;
        bus.rd_addr_i = addr;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; flush_i = 1'b0; bus.ready_i = 1'b1;
        drive(1'b0, 2'b00, '0, '0, '0);
        step(); step();
        vectors++; if (bus.valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
        vectors++; if (bus.rd_o !== 32'h0) begin miscompares++; $display("FAIL reset_rd: got %h want 0", bus.rd_o); end
        vectors++; if (bus.rd_addr_o !== 5'd0) begin miscompares++; $display("FAIL reset_addr: got %0d want 0", bus.rd_addr_o); end
        vectors++; if (bus.ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", bus.ready_o); end
        vectors++; if (op_count_o !== '0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", op_count_o); end
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_srl_basic();
        drive(1'b1, 2'b01, 32'h8000_0000, 32'd31, 5'd5);
        step();
        drive(1'b0, 2'b00, '0, '0, '0);
        vectors++; if (bus.valid_o !== 1'b0) begin miscompares++; $display("FAIL srl_lat1_valid: got %b want 0", bus.valid_o); end
        step();
        vectors++; if (bus.valid_o !== 1'b1) begin miscompares++; $display("FAIL srl_valid: got %b want 1", bus.valid_o); end
        vectors++; if (bus.rd_o !== 32'h0000_0001) begin miscompares++; $display("FAIL srl_rd: got %h want 00000001", bus.rd_o); end
        vectors++; if (bus.rd_addr_o !== 5'd5) begin miscompares++; $display("FAIL srl_addr: got %0d want 5", bus.rd_addr_o); end
        step();
        exp_cnt = 1;
        vectors++; if (op_count_o !== exp_cnt) begin miscompares++; $display("FAIL srl_cnt: got %0d want %0d", op_count_o, exp_cnt); end
        vectors++; if (bus.valid_o !== 1'b0) begin miscompares++; $display("FAIL srl_drain: got %b want 0", bus.valid_o); end
    endtask

    task automatic test_directed();
        logic [1:0]  t_op  [8] = '{2'b11, 2'b00, 2'b01, 2'b11, 2'b11, 2'b10, 2'b00, 2'b11};
        logic [31:0] t_rs1 [8] = '{32'h8000_0000, 32'h1, 32'h1234_5678, 32'h7FFF_FFFF,
                                   32'hF000_0000, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] t_rs2 [8] = '{32'h24, 32'h21, 32'h0, 32'd31, 32'h0, 32'd5, 32'd31, 32'd31};
        logic [31:0] t_exp [8] = '{32'hF800_0000, 32'h2, 32'h1234_5678, 32'h0,
                                   32'hF000_0000, 32'hDEAD_BEEF, 32'h8000_0000, 32'hFFFF_FFFF};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, t_op[i], t_rs1[i], t_rs2[i], 5'(i + 8));
            step();
            drive(1'b0, 2'b00, '0, '0, '0);
            step();
            vectors++; if (bus.rd_o !== t_exp[i]) begin miscompares++; $display("FAIL dir%0d_rd: got %h want %h", i, bus.rd_o, t_exp[i]); end
            vectors++; if (bus.rd_addr_o !== 5'(i + 8)) begin miscompares++; $display("FAIL dir%0d_addr: got %0d want %0d", i, bus.rd_addr_o, i + 8); end
            step();
            exp_cnt++;
        end
        vectors++; if (op_count_o !== exp_cnt) begin miscompares++; $display("FAIL dir_cnt: got %0d want %0d", op_count_o, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ops   [N_B2B];
        logic [31:0] exp_r [N_B2B];
        logic [31:0] a, b;
        for (int k = 0; k <= N_B2B + 1; k++) begin
            if (k < N_B2B) begin
                a = $urandom; b = $urandom;
                case ($urandom_range(0, 3))
                    0:       ops[k] = 2'b00;
                    1:       ops[k] = 2'b11;
                    default: ops[k] = 2'b01;
                endcase
                exp_r[k] = ref_shift(ops[k], a, b);
                drive(1'b1, ops[k], a, b, 5'(k));
            end else begin
                drive(1'b0, 2'b00, '0, '0, '0);
            end
            step();
            if (k >= 1 && k <= N_B2B) begin
                vectors++; if (bus.valid_o !== 1'b1 || bus.rd_o !== exp_r[k-1] || bus.rd_addr_o !== 5'(k-1)) begin
                    miscompares++;
                    $display("FAIL b2b%0d: got v=%b rd=%h a=%0d want v=1 rd=%h a=%0d",
                             k - 1, bus.valid_o, bus.rd_o, bus.rd_addr_o, exp_r[k-1], 5'(k-1));
                end
            end
        end
        exp_cnt += N_B2B;
        vectors++; if (op_count_o !== exp_cnt) begin miscompares++; $display("FAIL b2b_cnt: got %0d want %0d", op_count_o, exp_cnt); end
        vectors++; if (bus.valid_o !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: got %b want 0", bus.valid_o); end
    endtask

    task automatic test_backpressure();
        bus.ready_i = 1'b0;
        drive(1'b1, 2'b00, 32'h0000_00F0, 32'd4, 5'd1);   // 0xF00
        step();
        vectors++; if (bus.ready_o !== 1'b1) begin miscompares++; $display("FAIL bp_ready1: got %b want 1", bus.ready_o); end
        drive(1'b1, 2'b11, 32'h8000_0010, 32'd4, 5'd2);   // 0xF8000001
        step();
        drive(1'b1, 2'b01, 32'hA5A5_0000, 32'd16, 5'd3);  // 0x0000A5A5
        for (int c = 0; c < 5; c++) begin
            vectors++; if (bus.ready_o !== 1'b0 || bus.valid_o !== 1'b1 || bus.rd_o !== 32'h0000_0F00 || bus.rd_addr_o !== 5'd1) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got r=%b v=%b rd=%h a=%0d want r=0 v=1 rd=00000f00 a=1",
                         c, bus.ready_o, bus.valid_o, bus.rd_o, bus.rd_addr_o);
            end
            step();
        end
        bus.ready_i = 1'b1;
        step();
        drive(1'b0, 2'b00, '0, '0, '0);
        exp_cnt++;
        vectors++; if (bus.rd_o !== 32'hF800_0001 || bus.rd_addr_o !== 5'd2) begin miscompares++; $display("FAIL bp_op2: got rd=%h a=%0d want f8000001 a=2", bus.rd_o, bus.rd_addr_o); end
        vectors++; if (op_count_o !== exp_cnt) begin miscompares++; $display("FAIL bp_cnt1: got %0d want %0d", op_count_o, exp_cnt); end
        step();
        exp_cnt++;
        vectors++; if (bus.valid_o !== 1'b1 || bus.rd_o !== 32'h0000_A5A5 || bus.rd_addr_o !== 5'd3) begin miscompares++; $display("FAIL bp_op3: got v=%b rd=%h a=%0d want v=1 rd=0000a5a5 a=3", bus.valid_o, bus.rd_o, bus.rd_addr_o); end
        step();
        exp_cnt++;
        vectors++; if (bus.valid_o !== 1'b0) begin miscompares++; $display("FAIL bp_drain: got %b want 0", bus.valid_o); end
        vectors++; if (op_count_o !== exp_cnt) begin miscompares++; $display("FAIL bp_cnt: got %0d want %0d", op_count_o, exp_cnt); end
    endtask

    task automatic test_flush();
        bus.ready_i = 1'b0;
        drive(1'b1, 2'b00, 32'h1, 32'd1, 5'd10);
        step();
        drive(1'b1, 2'b00, 32'h1, 32'd2, 5'd11);
        step();
        drive(1'b1, 2'b00, 32'h1, 32'd3, 5'd12);
        bus.ready_i = 1'b1;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        drive(1'b0, 2'b00, '0, '0, '0);
        vectors++; if (bus.valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b want 0", bus.valid_o); end
        vectors++; if (bus.ready_o !== 1'b1) begin miscompares++; $display("FAIL flush_ready: got %b want 1", bus.ready_o); end
        vectors++; if (op_count_o !== exp_cnt) begin miscompares++; $display("FAIL flush_cnt: got %0d want %0d", op_count_o, exp_cnt); end
        step();
        vectors++; if (bus.valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_ghost: got %b want 0", bus.valid_o); end
        drive(1'b1, 2'b11, 32'hC000_0000, 32'd1, 5'd13);
        step();
        drive(1'b0, 2'b00, '0, '0, '0);
        step();
        vectors++; if (bus.valid_o !== 1'b1 || bus.rd_o !== 32'hE000_0000 || bus.rd_addr_o !== 5'd13) begin miscompares++; $display("FAIL flush_after: got v=%b rd=%h a=%0d want v=1 rd=e0000000 a=13", bus.valid_o, bus.rd_o, bus.rd_addr_o); end
        step();
        exp_cnt++;
        vectors++; if (op_count_o !== exp_cnt) begin miscompares++; $display("FAIL flush_cnt2: got %0d want %0d", op_count_o, exp_cnt); end
    endtask

    task automatic test_reset_mid();
        bus.ready_i = 1'b0;
        drive(1'b1, 2'b00, 32'h3, 32'd8, 5'd20);
        step();
        drive(1'b0, 2'b00, '0, '0, '0);
        step();
        vectors++; if (bus.valid_o !== 1'b1 || bus.rd_o !== 32'h0000_0300) begin miscompares++; $display("FAIL rmid_pre: got v=%b rd=%h want v=1 rd=00000300", bus.valid_o, bus.rd_o); end
        rst_ni = 1'b0;
        #1;
        vectors++; if (bus.valid_o !== 1'b0) begin miscompares++; $display("FAIL rmid_valid: got %b want 0", bus.valid_o); end
        vectors++; if (bus.rd_o !== 32'h0 || bus.rd_addr_o !== 5'd0) begin miscompares++; $display("FAIL rmid_data: got rd=%h a=%0d want 0 0", bus.rd_o, bus.rd_addr_o); end
        vectors++; if (op_count_o !== '0) begin miscompares++; $display("FAIL rmid_cnt: got %0d want 0", op_count_o); end
        vectors++; if (bus.ready_o !== 1'b1) begin miscompares++; $display("FAIL rmid_ready: got %b want 1", bus.ready_o); end
        #1;
        rst_ni = 1'b1;
        exp_cnt = '0;
        bus.ready_i = 1'b1;
        step();
        drive(1'b1, 2'b01, 32'hFFFF_0000, 32'hE4, 5'd21); // shamt 4
        step();
        drive(1'b0, 2'b00, '0, '0, '0);
        step();
        vectors++; if (bus.valid_o !== 1'b1 || bus.rd_o !== 32'h0FFF_F000 || bus.rd_addr_o !== 5'd21) begin miscompares++; $display("FAIL rmid_resume: got v=%b rd=%h a=%0d want v=1 rd=0ffff000 a=21", bus.valid_o, bus.rd_o, bus.rd_addr_o); end
        step();
        exp_cnt++;
        vectors++; if (op_count_o !== exp_cnt) begin miscompares++; $display("FAIL rmid_cnt2: got %0d want %0d", op_count_o, exp_cnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_srl_basic();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

`default_nettype wire
